// File: rtl/fs_ds_inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fs_ds_inst_buffer
//  Purpose  : Instruction FIFO between fetch and decode. It queues fetched
//             bundles so fetch can keep issuing while decode stalls.
//             Redirects (exception, ertn, branch) empty the queue. A bundle
//             that carries an exception blocks further pushes until the
//             resulting flush arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module fs_ds_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 81
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_to_ib_valid,
  input  logic [BUS_WD-1:0] fs_to_ib_bus,
  output logic              ib_allowin,
  output logic              ib_to_ds_valid,
  output logic [BUS_WD-1:0] ib_to_ds_bus,
  input  logic              ds_allowin,
  input  logic              excp_flush,
  input  logic              ertn_flush,
  input  logic              br_flush
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [BUS_WD-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_blk;

  logic w_flush;
  logic w_push;
  logic w_pop;

  // Handshake terms; allowin looks only at registered state so that fetch
  // never sees a combinational path from decode's stall.
  always_comb begin
    w_flush        = excp_flush | ertn_flush | br_flush;
    ib_allowin     = (r_count != C_FULL) && !r_blk;
    ib_to_ds_valid = (r_count != '0);
    w_push         = fs_to_ib_valid && ib_allowin && !w_flush;
    w_pop          = ib_to_ds_valid && ds_allowin && !w_flush;
    ib_to_ds_bus   = ib_to_ds_valid ? r_mem[r_rptr] : '0;
  end

  // Storage array; contents are never reset because the output is gated.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= fs_to_ib_bus;
    end
  end

  // Pointers, occupancy and exception block flag.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_blk   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        // The faulting bundle is the last one admitted before the redirect.
        if (fs_to_ib_bus[64]) begin
          r_blk <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fs_ds_inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fs_ds_inst_buffer
//  Purpose  : Self-checking bench for fs_ds_inst_buffer. A queue-based model
//             of the buffer predicts the outputs every cycle; directed
//             scenarios are followed by biased random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fs_ds_inst_buffer;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 81;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_to_ib_valid;
  logic [BUS_WD-1:0] fs_to_ib_bus;
  logic              ib_allowin;
  logic              ib_to_ds_valid;
  logic [BUS_WD-1:0] ib_to_ds_bus;
  logic              ds_allowin;
  logic              excp_flush;
  logic              ertn_flush;
  logic              br_flush;

  fs_ds_inst_buffer #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ib_valid (fs_to_ib_valid),
    .fs_to_ib_bus   (fs_to_ib_bus),
    .ib_allowin     (ib_allowin),
    .ib_to_ds_valid (ib_to_ds_valid),
    .ib_to_ds_bus   (ib_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .excp_flush     (excp_flush),
    .ertn_flush     (ertn_flush),
    .br_flush       (br_flush)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of resident bundles plus the block flag.
  logic [BUS_WD-1:0] m_q[$];
  bit                m_blk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc, input logic excp,
                                           input logic [15:0] num);
    logic [31:0] inst;
    inst = $urandom;
    return {num, excp, inst, pc};
  endfunction

  function automatic bit m_allowin();
    return (m_q.size() < DEPTH) && !m_blk;
  endfunction

  task automatic check_outputs(input string tag);
    logic [BUS_WD-1:0] exp_bus;
    exp_bus = (m_q.size() != 0) ? m_q[0] : '0;
    check_val({tag, "_valid"},   128'(ib_to_ds_valid), 128'(m_q.size() != 0));
    check_val({tag, "_bus"},     128'(ib_to_ds_bus),   128'(exp_bus));
    check_val({tag, "_allowin"}, 128'(ib_allowin),     128'(m_allowin()));
  endtask

  // One clock: check current outputs, apply inputs, advance the model.
  task automatic cyc(input string tag, input bit fv, input logic [BUS_WD-1:0] bus,
                     input bit da, input bit ex, input bit er, input bit br,
                     input bit rst, output bit accepted);
    bit pop;
    check_outputs(tag);
    fs_to_ib_valid = fv;
    fs_to_ib_bus   = bus;
    ds_allowin     = da;
    excp_flush     = ex;
    ertn_flush     = er;
    br_flush       = br;
    reset          = rst;
    accepted       = 1'b0;
    @(posedge clk);
    if (rst || ex || er || br) begin
      m_q.delete();
      m_blk = 1'b0;
    end else begin
      accepted = fv && m_allowin();
      pop      = (m_q.size() != 0) && da;
      if (pop) void'(m_q.pop_front());
      if (accepted) begin
        m_q.push_back(bus);
        if (bus[64]) m_blk = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    bit                acc;
    int                k;
    logic [BUS_WD-1:0] b;
    logic [BUS_WD-1:0] pend;
    bit                have_pend;

    fs_to_ib_valid = 0; fs_to_ib_bus = '0; ds_allowin = 0;
    excp_flush = 0; ertn_flush = 0; br_flush = 0; reset = 1;
    @(posedge clk); #1;
    cyc("rst", 0, '0, 0, 0, 0, 0, 1, acc);
    m_q.delete(); m_blk = 0;

    // Streaming with decode always ready.
    for (int i = 0; i < 3; i++) cyc("stream", 1, mk(32'h1c000000 + 4*i, 0, 0), 1, 0, 0, 0, 0, acc);
    cyc("stream_drain", 0, '0, 1, 0, 0, 0, 0, acc);

    // Fill with decode stalled; fetch holds the 5th bundle while refused.
    k = 0; b = mk(32'h1c000000, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc("fill", 1, b, 0, 0, 0, 0, 0, acc);
      if (acc) begin k++; b = mk(32'h1c000000 + 4*k, 0, 0); end
    end
    for (int i = 0; i < 8; i++) begin
      cyc("release", (k < 5), b, 1, 0, 0, 0, 0, acc);
      if (acc) begin k++; b = mk(32'h1c000000 + 4*k, 0, 0); end
    end

    // Wrap: two resident entries, then simultaneous push/pop.
    for (int i = 0; i < 2; i++) cyc("wrap_pre", 1, mk(32'h1c000100 + 4*i, 0, 0), 0, 0, 0, 0, 0, acc);
    for (int i = 0; i < 10; i++) cyc("wrap", 1, mk(32'h1c000108 + 4*i, 0, 0), 1, 0, 0, 0, 0, acc);
    cyc("wrap_flush", 0, '0, 0, 0, 0, 1, 0, acc);

    // Flush mid-stream from each source with an incoming bundle.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 3; i++) cyc("fl_pre", 1, mk(32'h1c000200 + 4*i, 0, 0), 0, 0, 0, 0, 0, acc);
      cyc("fl", 1, mk(32'h1c0002f0, 0, 0), 1, (s == 1), (s == 2), (s == 0), 0, acc);
      cyc("fl_post", 0, '0, 0, 0, 0, 0, 0, acc);
    end

    // Exception block: faulting bundle then two more offers.
    cyc("excp", 1, mk(32'h1c000300, 1, 16'h4000), 0, 0, 0, 0, 0, acc);
    cyc("excp_blk1", 1, mk(32'h1c000304, 0, 0), 0, 0, 0, 0, 0, acc);
    cyc("excp_blk2", 1, mk(32'h1c000308, 0, 0), 0, 0, 0, 0, 0, acc);
    cyc("excp_flush", 0, '0, 0, 1, 0, 0, 0, acc);
    cyc("excp_after", 0, '0, 0, 0, 0, 0, 0, acc);

    // Reset in the middle of operation.
    for (int i = 0; i < 2; i++) cyc("rm_pre", 1, mk(32'h1c000400 + 4*i, 0, 0), 0, 0, 0, 0, 0, acc);
    cyc("rm_reset", 1, mk(32'h1c0004f0, 0, 0), 1, 0, 0, 0, 1, acc);
    cyc("rm_push", 1, mk(32'h1c000500, 0, 0), 0, 0, 0, 0, 0, acc);
    cyc("rm_head", 0, '0, 1, 0, 0, 0, 0, acc);

    // Biased random traffic; fetch holds a refused bundle like real fetch.
    have_pend = 0; pend = '0; k = 0;
    for (int i = 0; i < 2000; i++) begin
      bit fv, da, ex, er, br;
      if (!have_pend && ($urandom_range(0, 9) < 7)) begin
        pend = mk(32'h1c010000 + 4*k, ($urandom_range(0, 19) == 0), 16'($urandom));
        k++;
        have_pend = 1;
      end
      fv = have_pend;
      da = ($urandom_range(0, 9) < 6);
      ex = ($urandom_range(0, 59) == 0);
      er = ($urandom_range(0, 79) == 0);
      br = ($urandom_range(0, 39) == 0);
      if (m_blk && m_q.size() != 0 && $urandom_range(0, 3) == 0) ex = 1;
      cyc("rand", fv, pend, da, ex, er, br, ($urandom_range(0, 299) == 0), acc);
      if (acc || ex || er || br) have_pend = 0;
    end
    check_outputs("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
